// File: rtl/fifo_push_arbiter_if.sv
// Producer/consumer-facing bundle of the FIFO push arbiter: requests, pop observation, push side and status.
// master = producers plus the consumer's pop strobe; slave = the arbiter.
interface fifo_push_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      pop;
  logic                      push;
  logic [DATA_W-1:0]         wdata;
  logic [CNT_W-1:0]          count;
  logic                      full;
  logic                      empty;
  logic                      stall;
  logic                      pop_err;

  modport master (
    output req_valid, req_data, pop,
    input  req_ready, push, wdata, count, full, empty, stall, pop_err
  );

  modport slave (
    input  req_valid, req_data, pop,
    output req_ready, push, wdata, count, full, empty, stall, pop_err
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin share of one FIFO push port; push/wdata follow an accept by 1 cycle.
// Backpressure: req_ready is withheld in STALL or while the tracked count sits at DEPTH.
module fifo_push_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               rst,
  fifo_push_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push_q, push_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                pop_err_q, pop_err_d;

  logic                gnt_vld;
  logic [IDX_W-1:0]    gnt_idx;
  int                  scan_idx;
  logic                xfer;
  logic                eff_pop;
  logic                any_valid;
  logic [NUM_REQ-1:0]  ready;

  // Search starts one past the last winner so the previous grantee goes last.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!gnt_vld && bus.req_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(scan_idx);
      end
    end
  end

  assign any_valid = |bus.req_valid;
  // Pop is deliberately absent here: freed space only becomes grantable next cycle.
  assign xfer      = gnt_vld && (state_q != STALL) && (count_q != DEPTH_C);
  assign eff_pop   = bus.pop && (count_q != '0);

  always_comb begin
    ready = '0;
    if (xfer) ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    unique case ({xfer, eff_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    rr_ptr_d  = xfer ? gnt_idx : rr_ptr_q;
    push_d    = xfer;
    wdata_d   = xfer ? bus.req_data[gnt_idx*DATA_W +: DATA_W] : wdata_q;
    pop_err_d = pop_err_q | (bus.pop && (count_q == '0));

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_valid) state_d = (count_q == DEPTH_C) ? STALL : GRANT;
      GRANT:   if (!any_valid) state_d = IDLE;
               else if (count_d == DEPTH_C) state_d = STALL;
      STALL:   if (!any_valid) state_d = IDLE;
               else if (count_d != DEPTH_C) state_d = GRANT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= RR_RESET;
      count_q   <= '0;
      push_q    <= 1'b0;
      wdata_q   <= '0;
      pop_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      count_q   <= count_d;
      push_q    <= push_d;
      wdata_q   <= wdata_d;
      pop_err_q <= pop_err_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.push      = push_q;
  assign bus.wdata     = wdata_q;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == DEPTH_C);
  assign bus.empty     = (count_q == '0);
  assign bus.stall     = (state_q == STALL);
  assign bus.pop_err   = pop_err_q;

  always @(posedge clk) begin
    if (!rst) begin
      a_onehot:      assert ($onehot0(bus.req_ready));
      a_no_ovf:      assert (!(bus.push && (count_q > DEPTH_C)));
      a_ready_valid: assert ((bus.req_ready & ~bus.req_valid) == '0);
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: reset, single grant, round robin, full/stall,
// simultaneous push+pop, underflow flag and asynchronous reset mid-burst.
module tb_fifo_push_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  fifo_push_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_push_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.pop       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.pop       = 1'b0;
    #2;
    n_checks++; if (bus.push !== 1'b0) begin n_fail++; $display("FAIL rst_push got=%b exp=0", bus.push); end
    n_checks++; if (bus.wdata !== 8'h00) begin n_fail++; $display("FAIL rst_wdata got=%h exp=00", bus.wdata); end
    n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_full got=%b exp=0", bus.full); end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got=%b exp=1", bus.empty); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
    n_checks++; if (bus.pop_err !== 1'b0) begin n_fail++; $display("FAIL rst_pop_err got=%b exp=0", bus.pop_err); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got=%b exp=0000", bus.req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_data  = 32'h0000_00A5;
    bus.req_valid = 4'b0001;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL t1_ready got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    n_checks++; if (bus.push !== 1'b1) begin n_fail++; $display("FAIL t1_push got=%b exp=1", bus.push); end
    n_checks++; if (bus.wdata !== 8'hA5) begin n_fail++; $display("FAIL t1_wdata got=%h exp=a5", bus.wdata); end
    n_checks++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL t1_count got=%0d exp=1", bus.count); end
    n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL t1_empty got=%b exp=0", bus.empty); end
    tick();
    n_checks++; if (bus.push !== 1'b0) begin n_fail++; $display("FAIL t1_push_once got=%b exp=0", bus.push); end
    n_checks++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL t1_count_hold got=%0d exp=1", bus.count); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    logic [7:0] exp_dat;
    do_reset();
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      exp_rdy = 4'b0001 << (c % 4);
      exp_dat = 8'h10 + 8'(c % 4);
      #1;
      n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL t2_ready[%0d] got=%b exp=%b", c, bus.req_ready, exp_rdy); end
      tick();
      n_checks++; if (bus.push !== 1'b1 || bus.wdata !== exp_dat) begin n_fail++; $display("FAIL t2_push[%0d] got=%b/%h exp=1/%h", c, bus.push, bus.wdata, exp_dat); end
      @(negedge clk);
    end
    bus.req_valid = 4'b0000;
    #1;
    n_checks++; if (bus.count !== 5'd8) begin n_fail++; $display("FAIL t2_count got=%0d exp=8", bus.count); end
  endtask

  task automatic test_full();
    do_reset();
    bus.req_data  = 32'h00C0_0000;
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL t3_fill_ready[%0d] got=%b exp=0100", i, bus.req_ready); end
      tick();
      @(negedge clk);
    end
    n_checks++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL t3_count got=%0d exp=16", bus.count); end
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL t3_full got=%b exp=1", bus.full); end
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL t3_stall got=%b exp=1", bus.stall); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL t3_ready got=%b exp=0000", bus.req_ready); end
    tick();
    n_checks++; if (bus.push !== 1'b0 || bus.count !== 5'd16) begin n_fail++; $display("FAIL t3_hold got=%b/%0d exp=0/16", bus.push, bus.count); end
    @(negedge clk);
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    n_checks++; if (bus.count !== 5'd15) begin n_fail++; $display("FAIL t3_pop_count got=%0d exp=15", bus.count); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL t3_pop_stall got=%b exp=0", bus.stall); end
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL t3_regrant got=%b exp=0100", bus.req_ready); end
    tick();
    n_checks++; if (bus.push !== 1'b1 || bus.wdata !== 8'hC0) begin n_fail++; $display("FAIL t3_push got=%b/%h exp=1/c0", bus.push, bus.wdata); end
    n_checks++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL t3_refill got=%0d exp=16", bus.count); end
    n_checks++; if (bus.stall !== 1'b1 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL t3_restall got=%b/%b exp=1/0000", bus.stall, bus.req_ready); end
    bus.req_valid = 4'b0000;
    tick();
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL t3_idle got=%b exp=0", bus.stall); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.req_data  = 32'h0000_3300;
    bus.req_valid = 4'b0010;
    repeat (5) tick();
    n_checks++; if (bus.count !== 5'd5) begin n_fail++; $display("FAIL t4_pre_count got=%0d exp=5", bus.count); end
    bus.pop      = 1'b1;
    bus.req_data = 32'h0000_5A00;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL t4_ready got=%b exp=0010", bus.req_ready); end
    tick();
    bus.pop       = 1'b0;
    bus.req_valid = 4'b0000;
    n_checks++; if (bus.count !== 5'd5) begin n_fail++; $display("FAIL t4_count got=%0d exp=5", bus.count); end
    n_checks++; if (bus.push !== 1'b1 || bus.wdata !== 8'h5A) begin n_fail++; $display("FAIL t4_push got=%b/%h exp=1/5a", bus.push, bus.wdata); end
    tick();
    n_checks++; if (bus.push !== 1'b0 || bus.count !== 5'd5) begin n_fail++; $display("FAIL t4_after got=%b/%0d exp=0/5", bus.push, bus.count); end
  endtask

  task automatic test_underflow();
    do_reset();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    n_checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL t5_count got=%0d/%b exp=0/1", bus.count, bus.empty); end
    n_checks++; if (bus.pop_err !== 1'b1) begin n_fail++; $display("FAIL t5_pop_err got=%b exp=1", bus.pop_err); end
    bus.req_data  = 32'h0000_0077;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0000;
    n_checks++; if (bus.count !== 5'd1 || bus.pop_err !== 1'b1) begin n_fail++; $display("FAIL t5_xfer got=%0d/%b exp=1/1", bus.count, bus.pop_err); end
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL t5_legal_pop got=%0d exp=0", bus.count); end
    repeat (3) tick();
    n_checks++; if (bus.pop_err !== 1'b1) begin n_fail++; $display("FAIL t5_sticky got=%b exp=1", bus.pop_err); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.pop_err !== 1'b0) begin n_fail++; $display("FAIL t5_rst_clear got=%b exp=0", bus.pop_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_valid = 4'b1111;
    repeat (7) tick();
    n_checks++; if (bus.push !== 1'b1 || bus.count !== 5'd7) begin n_fail++; $display("FAIL t6_pre got=%b/%0d exp=1/7", bus.push, bus.count); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.push !== 1'b0) begin n_fail++; $display("FAIL t6_push got=%b exp=0", bus.push); end
    n_checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL t6_count got=%0d/%b exp=0/1", bus.count, bus.empty); end
    n_checks++; if (dut.rr_ptr_q !== 2'd3) begin n_fail++; $display("FAIL t6_rr_ptr got=%0d exp=3", dut.rr_ptr_q); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL t6_first_grant got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    n_checks++; if (bus.push !== 1'b1 || bus.wdata !== 8'h10 || bus.count !== 5'd1) begin n_fail++; $display("FAIL t6_first_push got=%b/%h/%0d exp=1/10/1", bus.push, bus.wdata, bus.count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_simultaneous();
    test_underflow();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
